// File: rtl/alu_muldiv.sv
// Iterative multiply/divide unit: one bit per clock, fixed WIDTH+1 edge latency,
// start/busy/done handshake with synchronous abort.
module alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] data_rs,
  input  logic [WIDTH-1:0] data_rt,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             is_div;
  logic             neg_q;
  logic             neg_r;
  logic             dz;
  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  logic               rs_neg, rt_neg;
  logic [WIDTH-1:0]   rs_mag, rt_mag;
  logic [WIDTH:0]     add_sum, rem_shift, rem_diff;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // hi/lo are shared: product accumulator/multiplier for MUL, remainder/quotient for DIV.
  always_comb begin
    rs_neg    = op[0] & data_rs[WIDTH-1];
    rt_neg    = op[0] & data_rt[WIDTH-1];
    rs_mag    = rs_neg ? -data_rs : data_rs;
    rt_mag    = rt_neg ? -data_rt : data_rt;
    add_sum   = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
    rem_shift = {hi, lo[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, m};
    prod      = {hi, lo};
    prod_fix  = neg_q ? -prod : prod;
    quo_fix   = dz ? '1 : (neg_q ? -lo : lo);
    rem_fix   = neg_r ? -hi : hi;
  end

  // Divide by zero needs no special datapath: every trial subtract succeeds, so the
  // remainder is the dividend magnitude and the dividend-sign fix restores data_rs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      dz       <= 1'b0;
      m        <= '0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      res_hi   <= '0;
      res_lo   <= '0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            state  <= CALC;
            busy   <= 1'b1;
            cnt    <= '0;
            is_div <= op[1];
            neg_q  <= rs_neg ^ rt_neg;
            neg_r  <= op[1] & rs_neg;
            dz     <= op[1] && (data_rt == '0);
            m      <= rt_mag;
            lo     <= rs_mag;
            hi     <= '0;
          end
        end
        CALC: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            if (is_div) begin
              if (!rem_diff[WIDTH]) begin
                hi <= rem_diff[WIDTH-1:0];
                lo <= {lo[WIDTH-2:0], 1'b1};
              end else begin
                hi <= rem_shift[WIDTH-1:0];
                lo <= {lo[WIDTH-2:0], 1'b0};
              end
            end else begin
              hi <= add_sum[WIDTH:1];
              lo <= {add_sum[0], lo[WIDTH-1:1]};
            end
            cnt <= cnt + CW'(1);
            if (cnt == CW'(WIDTH - 1)) state <= FIX;
          end
        end
        FIX: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (!abort) begin
            done     <= 1'b1;
            div_zero <= dz;
            if (is_div) begin
              res_hi <= rem_fix;
              res_lo <= quo_fix;
            end else begin
              {res_hi, res_lo} <= prod_fix;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// Bench for alu_muldiv: drives a WIDTH=32 and a WIDTH=8 instance in turn and checks
// them against an arithmetic reference model.
module tb_alu_muldiv;

  typedef longint unsigned u64;

  typedef struct packed {
    logic [7:0]  lat;
    logic [7:0]  bcnt;
    logic        bsy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] rs = '0;
  logic [31:0] rt = '0;
  logic        sel8 = 1'b0;

  logic        b32, d32, z32, b8, d8, z8;
  logic [31:0] h32, l32;
  logic [7:0]  h8, l8;

  logic        busy_o, done_o, dz_o;
  logic [31:0] hi_o, lo_o;
  int          w;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  alu_muldiv #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .start(start & ~sel8), .op(op),
    .data_rs(rs), .data_rt(rt), .abort(abort & ~sel8),
    .busy(b32), .done(d32), .res_hi(h32), .res_lo(l32), .div_zero(z32)
  );

  alu_muldiv #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start & sel8), .op(op),
    .data_rs(rs[7:0]), .data_rt(rt[7:0]), .abort(abort & sel8),
    .busy(b8), .done(d8), .res_hi(h8), .res_lo(l8), .div_zero(z8)
  );

  assign busy_o = sel8 ? b8 : b32;
  assign done_o = sel8 ? d8 : d32;
  assign dz_o   = sel8 ? z8 : z32;
  assign hi_o   = sel8 ? {24'h0, h8} : h32;
  assign lo_o   = sel8 ? {24'h0, l8} : l32;
  assign w      = sel8 ? 8 : 32;

  function automatic logic [31:0] mask_of(input int wd);
    return (wd == 32) ? 32'hFFFF_FFFF : ((32'd1 << wd) - 32'd1);
  endfunction

  // Reference: plain 64-bit arithmetic on sign-extended or zero-extended operands.
  function automatic res_t exp_of(input int wd, input logic [1:0] o,
                                  input logic [31:0] a_in, input logic [31:0] b_in);
    res_t    e;
    u64      msk, ua, ub, up;
    longint  sa, sb, q, r;
    msk = (u64'(1) << wd) - 1;
    ua  = {32'h0, a_in & mask_of(wd)};
    ub  = {32'h0, b_in & mask_of(wd)};
    sa  = longint'(ua << (64 - wd));
    sa  = sa >>> (64 - wd);
    sb  = longint'(ub << (64 - wd));
    sb  = sb >>> (64 - wd);
    e      = '0;
    e.lat  = 8'(wd + 1);
    e.bcnt = 8'(wd + 1);
    if (!o[1]) begin
      if (o[0]) up = u64'(sa * sb);
      else      up = ua * ub;
      e.lo = 32'(up & msk);
      e.hi = 32'((up >> wd) & msk);
    end else if (ub == 0) begin
      e.lo = 32'(msk);
      e.hi = 32'(ua);
      e.dz = 1'b1;
    end else begin
      if (o[0]) begin
        q = sa / sb;
        r = sa % sb;
      end else begin
        q = longint'(ua / ub);
        r = longint'(ua % ub);
      end
      e.lo = 32'(u64'(q) & msk);
      e.hi = 32'(u64'(r) & msk);
    end
    return e;
  endfunction

  function automatic string fmt(input res_t r);
    return $sformatf("lat=%0d busy_cycles=%0d busy_at_done=%b hi=%h lo=%h dz=%b",
                     r.lat, r.bcnt, r.bsy, r.hi, r.lo, r.dz);
  endfunction

  // Issues one op, waits (bounded) for done and returns what was observed.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit noise, output res_t r);
    int n;
    int bc;
    @(negedge clk);
    start = 1'b1; op = o; rs = a; rt = b;
    @(posedge clk); #1;
    start = 1'b0; rs = $urandom; rt = $urandom;
    n = 0; bc = 0; r = '0;
    while (n < w + 6) begin
      if (busy_o) bc++;
      if (noise) begin
        start = (n >= 1 && n <= 4);
        op    = 2'($urandom_range(0, 3));
      end
      @(posedge clk); #1;
      n++;
      if (done_o) begin
        r.lat = 8'(n);
        break;
      end
    end
    start  = 1'b0;
    r.bcnt = 8'(bc);
    r.bsy  = busy_o;
    r.hi   = hi_o;
    r.lo   = lo_o;
    r.dz   = dz_o;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    compared++;
    if ({busy_o, done_o, dz_o, hi_o, lo_o} !== '0) begin
      mismatched++;
      $display("FAIL reset_w%0d: got busy=%b done=%b dz=%b hi=%h lo=%h want all zero",
               w, busy_o, done_o, dz_o, hi_o, lo_o);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    compared++;
    if (busy_o !== 1'b0 || done_o !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_release_w%0d: got busy=%b done=%b want 0 0", w, busy_o, done_o);
    end
  endtask

  task automatic test_directed();
    logic [1:0]  ops [6] = '{2'd0, 2'd1, 2'd3, 2'd3, 2'd2, 2'd2};
    logic [31:0] as  [6];
    logic [31:0] bs  [6];
    res_t r, e;
    as = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd1 << (w - 1), 32'd100, 32'd100};
    bs = '{32'hFFFF_FFFF, 32'd7,         32'd2,         32'hFFFF_FFFF,    32'd0,   32'd7};
    for (int i = 0; i < 6; i++) begin
      run_op(ops[i], as[i], bs[i], 1'b0, r);
      e = exp_of(w, ops[i], as[i], bs[i]);
      compared++;
      if (r !== e) begin
        mismatched++;
        $display("FAIL directed%0d_w%0d: got %s want %s", i, w, fmt(r), fmt(e));
      end
    end
  endtask

  task automatic test_random(input int count);
    logic [1:0]  o;
    logic [31:0] a, b;
    res_t r, e;
    for (int i = 0; i < count; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: b = '1;
        2: begin a = 32'd1 << (w - 1); b = '1; end
        3: a = '1;
        4: a = '0;
        default: ;
      endcase
      run_op(o, a, b, 1'b0, r);
      e = exp_of(w, o, a, b);
      compared++;
      if (r !== e) begin
        mismatched++;
        $display("FAIL random%0d_w%0d op=%0d rs=%h rt=%h: got %s want %s",
                 i, w, o, a, b, fmt(r), fmt(e));
      end
      @(posedge clk); #1;
      compared++;
      if (done_o !== 1'b0) begin
        mismatched++;
        $display("FAIL done_pulse_w%0d: got done=%b want 0", w, done_o);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  o [3] = '{2'd1, 2'd3, 2'd0};
    logic [31:0] a, b;
    res_t r, e;
    for (int i = 0; i < 3; i++) begin
      a = $urandom;
      b = $urandom | 32'd1;
      if (i > 0) begin
        compared++;
        if (done_o !== 1'b1) begin
          mismatched++;
          $display("FAIL b2b_done_cycle_w%0d: got done=%b want 1", w, done_o);
        end
      end
      run_op(o[i], a, b, 1'b0, r);
      e = exp_of(w, o[i], a, b);
      compared++;
      if (r !== e) begin
        mismatched++;
        $display("FAIL b2b%0d_w%0d: got %s want %s", i, w, fmt(r), fmt(e));
      end
    end
  endtask

  task automatic test_start_busy();
    logic [31:0] a, b;
    bit   seen;
    res_t r, e;
    a = $urandom;
    b = $urandom;
    run_op(2'd0, a, b, 1'b1, r);
    e = exp_of(w, 2'd0, a, b);
    compared++;
    if (r !== e) begin
      mismatched++;
      $display("FAIL start_busy_w%0d: got %s want %s", w, fmt(r), fmt(e));
    end
    seen = 1'b0;
    for (int i = 0; i < w + 3; i++) begin
      @(posedge clk); #1;
      if (busy_o || done_o) seen = 1'b1;
    end
    compared++;
    if (seen) begin
      mismatched++;
      $display("FAIL start_busy_queued_w%0d: got extra busy/done=1 want 0", w);
    end
  endtask

  task automatic test_abort();
    int   edges [2];
    bit   seen;
    res_t r, e;
    edges = '{(w >= 16) ? 10 : 5, w + 1};
    for (int k = 0; k < 2; k++) begin
      run_op(2'd0, 32'd5, 32'd6, 1'b0, r);
      e = exp_of(w, 2'd0, 32'd5, 32'd6);
      compared++;
      if (r !== e) begin
        mismatched++;
        $display("FAIL abort_pre_w%0d: got %s want %s", w, fmt(r), fmt(e));
      end
      @(negedge clk);
      start = 1'b1; op = 2'd2; rs = 32'd9; rt = 32'd3;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (edges[k] - 1) @(posedge clk);
      #1 abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      compared++;
      if (busy_o !== 1'b0 || done_o !== 1'b0) begin
        mismatched++;
        $display("FAIL abort_e%0d_w%0d: got busy=%b done=%b want 0 0", edges[k], w, busy_o, done_o);
      end
      seen = 1'b0;
      for (int i = 0; i < w + 3; i++) begin
        @(posedge clk); #1;
        if (busy_o || done_o) seen = 1'b1;
      end
      compared++;
      if (seen || hi_o !== 32'd0 || lo_o !== 32'd30 || dz_o !== 1'b0) begin
        mismatched++;
        $display("FAIL abort_hold_e%0d_w%0d: got activity=%b hi=%h lo=%h dz=%b want 0 0 1e 0",
                 edges[k], w, seen, hi_o, lo_o, dz_o);
      end
    end
    @(negedge clk);
    start = 1'b1; abort = 1'b1; op = 2'd0; rs = 32'd7; rt = 32'd7;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    seen = busy_o;
    for (int i = 0; i < w + 3; i++) begin
      @(posedge clk); #1;
      if (busy_o || done_o) seen = 1'b1;
    end
    compared++;
    if (seen || hi_o !== 32'd0 || lo_o !== 32'd30) begin
      mismatched++;
      $display("FAIL start_abort_idle_w%0d: got activity=%b hi=%h lo=%h want 0 0 1e", w, seen, hi_o, lo_o);
    end
  endtask

  task automatic test_reset_mid();
    int   redge;
    bit   seen;
    res_t r, e;
    redge = (w >= 16) ? 15 : 5;
    run_op(2'd2, 32'd100, 32'd0, 1'b0, r);
    e = exp_of(w, 2'd2, 32'd100, 32'd0);
    compared++;
    if (r !== e) begin
      mismatched++;
      $display("FAIL reset_mid_pre_w%0d: got %s want %s", w, fmt(r), fmt(e));
    end
    @(negedge clk);
    start = 1'b1; op = 2'd1; rs = 32'hFFFF_FFFD; rt = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (redge) @(posedge clk);
    #1;
    compared++;
    if (busy_o !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_mid_busy_w%0d: got busy=%b want 1", w, busy_o);
    end
    #1 rst_n = 1'b0;
    #1;
    compared++;
    if ({busy_o, done_o, dz_o, hi_o, lo_o} !== '0) begin
      mismatched++;
      $display("FAIL reset_mid_w%0d: got busy=%b done=%b dz=%b hi=%h lo=%h want all zero",
               w, busy_o, done_o, dz_o, hi_o, lo_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < w + 3; i++) begin
      @(posedge clk); #1;
      if (busy_o || done_o) seen = 1'b1;
    end
    compared++;
    if (seen) begin
      mismatched++;
      $display("FAIL reset_mid_done_w%0d: got activity after reset want none", w);
    end
  endtask

  initial begin
    for (int pass = 0; pass < 2; pass++) begin
      sel8 = (pass == 1);
      test_reset();
      test_directed();
      test_random(pass == 1 ? 150 : 40);
      test_back_to_back();
      test_start_busy();
      test_abort();
      test_reset_mid();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
